ripemd160_right_seq: RTL and testbench
======================================

Name: ripemd160_right_seq

Overview:
Sequencer for the RIPEMD-160 right (parallel) line.
- Accepts one 512-bit message block and a 160-bit chaining value.
- Drives the external right-line step datapath for 80 steps, one step per clock.
- Owns the working-state register and returns the 160-bit right-line result to the compression top level.
- Selects the per-step message word, rotate amount, constant and function code.

Parameters:
- NSTEPS, 80, steps per block. Fixed for RIPEMD-160. Must equal 5*16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  block and chaining value are valid.
- in_ready  out  1  sequencer can accept a block.
- block_in  in  512  message words; X[i] = block_in[32*i+31:32*i], already little-endian.
- h_in  in  160  initial {A,B,C,D,E}; A in [159:128].
- sb_data  out  160  current working state {A,B,C,D,E} to the step datapath.
- sb_m  out  32  X[r'(j)].
- sb_s  out  8  rotate amount s'(j), range 5..15.
- sb_k  out  32  K'(j/16).
- sb_t  out  3  round index j/16. Codes 0..4 select F5,F4,F3,F2,F1 in the datapath.
- sb_result  in  160  datapath output. The B slot is rol(A+f+m+K, s) without the +E term.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  160  right-line final {A,B,C,D,E}.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; step=0; work=0; in_ready=0 while in reset; out_valid=0; result=0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch block_in into the message register, load work=h_in, step=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, sb_* are combinationally driven from work and step.
  - At the clock edge, work is updated from sb_result, with next B = sb_result[127:96] + work[31:0] (E before the step, mod 2^32). All other slots are taken as-is.
  - step increments.
  - On the edge where step==79, go to DONE with result=the updated work.
- DONE:
  - out_valid=1; result is held stable.
  - On out_ready, go to IDLE and clear out_valid.
  - No new block is accepted in the same cycle; in_ready rises in the following cycle.
- Latency: acceptance at edge N gives out_valid high after edge N+80. Throughput is 1 block per 81 cycles minimum, plus handshake.
- sb_* outside RUN: sb_t=0, sb_s=0, sb_k=0, sb_m=0, sb_data=work. The datapath output is ignored.
- Message register is only written at acceptance. Changes on block_in during RUN have no effect.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid is produced.
- K' by round: 0x50A28BE6, 0x5C4DD124, 0x6D703EF3, 0x7A6D76E9, 0x00000000.
- r' table:
  - round 0: 5,14,7,0,9,2,11,4,13,6,15,8,1,10,3,12
  - round 1: 6,11,3,7,0,13,5,10,14,15,8,12,4,9,1,2
  - round 2: 15,5,1,3,7,14,6,9,11,8,12,2,10,0,4,13
  - round 3: 8,6,4,1,3,11,15,0,5,12,2,13,9,7,10,14
  - round 4: 12,15,10,4,1,5,8,7,6,2,13,14,0,3,9,11
- s' table:
  - round 0: 8,9,9,11,13,15,15,5,7,7,8,11,14,14,12,6
  - round 1: 9,13,15,7,12,8,9,11,7,7,12,7,6,15,13,11
  - round 2: 9,7,15,11,8,6,6,14,12,13,5,14,13,13,7,5
  - round 3: 15,5,8,11,14,14,6,14,6,9,12,9,12,5,15,8
  - round 4: 8,5,12,9,12,5,14,6,8,13,6,5,15,13,11,11

Optional Feature:
- Macro: RIPEMD_RIGHT_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in RUN or DONE returns to IDLE at the next edge. out_valid is cleared, step=0, work is unchanged, and in_ready=1 on the following cycle.
  - abort in IDLE is ignored.
  - abort has priority over the completion transition when step==79.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Package ripemd160_pkg:
  - state enum (IDLE, RUN, DONE);
  - K_RIGHT[5] array;
  - R_RIGHT[80] and S_RIGHT[80] constant arrays;
  - NSTEPS;
  - word/state typedefs (32-bit word, 160-bit state).
- One sub-module, ripemd160_right_rom: combinational lookup from step[6:0] to {r' index, s', K', t}. It is shared with the future left-line sequencer via a parameter that selects the table set.

Test Plan:
- Reset: assert rst_n=0 mid-RUN at step 40 -> out_valid=0, in_ready=1 one cycle after release, no result emitted.
- Schedule outputs:
  - step 0: index 5, s=8, K=0x50A28BE6, t=0.
  - step 15: index 12, s=6.
  - step 16: index 6, s=9, K=0x5C4DD124, t=1.
  - step 79: index 11, s=11, K=0, t=4.
- Golden vector: block = padded empty message (X[0]=0x00000080, others 0), h_in=67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0, with a reference software datapath model -> result matches the software right-line result, and out_valid appears exactly 80 cycles after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles -> result stable, in_ready=0; raise out_ready -> IDLE next cycle, second block accepted.
- +E rule: stub datapath returning B slot 0xFFFFFFFF with E=0x00000002 -> next B=0x00000001 (wrap).
- With RIPEMD_RIGHT_SEQ_ABORT_EN: abort at step 79 -> no out_valid; in_ready=1 in the next cycle.

Source files
------------

// File: rtl/ripemd160_pkg.sv
// Shared types and step-schedule tables for the RIPEMD-160 sequencers.
// Both the right (parallel) and left line tables live here so one ROM serves either line.
package ripemd160_pkg;

  localparam int unsigned NSTEPS = 80;

  typedef logic [31:0]  word_t;
  typedef logic [159:0] hstate_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  localparam word_t K_RIGHT [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3,
                                   32'h7A6D76E9, 32'h00000000};
  localparam word_t K_LEFT  [5] = '{32'h00000000, 32'h5A827999, 32'h6ED9EBA1,
                                   32'h8F1BBCDC, 32'hA953FD4E};

  localparam logic [3:0] R_RIGHT [80] = '{
    5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
    6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
    15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
    8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
    12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};

  localparam logic [3:0] S_RIGHT [80] = '{
    8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
    9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
    9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
    15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
    8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};

  localparam logic [3:0] R_LEFT [80] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
    3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
    1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
    4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};

  localparam logic [3:0] S_LEFT [80] = '{
    11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};

endpackage

// File: rtl/ripemd160_right_rom.sv
// Step schedule lookup: step -> {message word index, rotate amount, constant, round}.
// LEFT_LINE selects the left-line table set for reuse by the left sequencer.
module ripemd160_right_rom
  import ripemd160_pkg::*;
#(
  parameter bit LEFT_LINE = 1'b0
) (
  input  logic [6:0] step,
  output logic [3:0] r_idx,
  output logic [7:0] s_amt,
  output word_t      k,
  output logic [2:0] t
);

  always_comb begin
    r_idx = '0;
    s_amt = '0;
    k     = '0;
    t     = '0;
    if (step < 7'(NSTEPS)) begin
      t = step[6:4];
      if (LEFT_LINE) begin
        r_idx = R_LEFT[step];
        s_amt = {4'b0, S_LEFT[step]};
        k     = K_LEFT[t];
      end else begin
        r_idx = R_RIGHT[step];
        s_amt = {4'b0, S_RIGHT[step]};
        k     = K_RIGHT[t];
      end
    end
  end

endmodule

// File: rtl/ripemd160_right_seq.sv
// RIPEMD-160 right-line sequencer: drives an external step datapath for 80 steps per block.
// Optional macro RIPEMD_RIGHT_SEQ_ABORT_EN adds an abort input that returns RUN/DONE to IDLE.
module ripemd160_right_seq
  import ripemd160_pkg::*;
#(
  parameter int unsigned NSTEPS = ripemd160_pkg::NSTEPS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [511:0]   block_in,
  input  logic [159:0]   h_in,
  output logic [159:0]   sb_data,
  output logic [31:0]    sb_m,
  output logic [7:0]     sb_s,
  output logic [31:0]    sb_k,
  output logic [2:0]     sb_t,
  input  logic [159:0]   sb_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [159:0]   result
`ifdef RIPEMD_RIGHT_SEQ_ABORT_EN
  ,
  input  logic           abort
`endif
);

  seq_state_e   state;
  logic [6:0]   step;
  hstate_t      work;
  hstate_t      work_next;
  logic [511:0] msg;
  logic [3:0]   r_idx;
  logic [7:0]   rom_s;
  word_t        rom_k;
  logic [2:0]   rom_t;
  logic [8:0]   m_base;
  logic         abort_req;
  logic         last_step;

`ifdef RIPEMD_RIGHT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  ripemd160_right_rom #(
    .LEFT_LINE(1'b0)
  ) u_rom (
    .step  (step),
    .r_idx (r_idx),
    .s_amt (rom_s),
    .k     (rom_k),
    .t     (rom_t)
  );

  assign last_step = (step == 7'(NSTEPS - 1));

  // The datapath leaves +E out of the B slot; it is added here against the pre-step E.
  always_comb begin
    work_next = {sb_result[159:128], sb_result[127:96] + work[31:0], sb_result[95:0]};
    m_base    = {r_idx, 5'b0};
    sb_data   = work;
    sb_m      = '0;
    sb_s      = '0;
    sb_k      = '0;
    sb_t      = '0;
    if (state == RUN) begin
      sb_m = msg[m_base +: 32];
      sb_s = rom_s;
      sb_k = rom_k;
      sb_t = rom_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      work      <= '0;
      msg       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (abort_req && state != IDLE) begin
      state     <= IDLE;
      step      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            msg      <= block_in;
            work     <= h_in;
            step     <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          work <= work_next;
          if (last_step) begin
            step      <= '0;
            result    <= work_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            step <= step + 7'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripemd160_right_seq.sv
// Bench for ripemd160_right_seq: software step datapath, scoreboard of expected results,
// and an empty-message digest cross-check combining a software left line with the DUT result.
module tb_ripemd160_right_seq;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, stub_mode;
  logic [511:0] block_in;
  logic [159:0] h_in, sb_data, sb_result, result;
  logic [31:0]  sb_m, sb_k;
  logic [7:0]   sb_s;
  logic [2:0]   sb_t;
`ifdef RIPEMD_RIGHT_SEQ_ABORT_EN
  logic         abort;
`endif

  always #5 clk = ~clk;

  ripemd160_right_seq #(.NSTEPS(80)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .block_in(block_in), .h_in(h_in), .sb_data(sb_data), .sb_m(sb_m),
    .sb_s(sb_s), .sb_k(sb_k), .sb_t(sb_t), .sb_result(sb_result),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef RIPEMD_RIGHT_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  localparam int RR[80] = '{
    5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
    6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
    15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
    8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
    12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};
  localparam int SR[80] = '{
    8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
    9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
    9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
    15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
    8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};
  localparam int RL[80] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
    3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
    1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
    4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};
  localparam int SL[80] = '{
    11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};
  localparam logic [31:0] KR[5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h0};
  localparam logic [31:0] KL[5] = '{32'h0, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E};
  localparam logic [159:0] H0 = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [7:0] s);
    return (x << s) | (x >> (8'd32 - s));
  endfunction

  // Step datapath: code 0..4 = F5,F4,F3,F2,F1; B slot excludes +E.
  function automatic logic [159:0] dp_step(input logic [159:0] w, input logic [31:0] m,
                                           input logic [31:0] k, input logic [7:0] s,
                                           input logic [2:0] t);
    logic [31:0] a, b, c, d, e, f;
    {a, b, c, d, e} = w;
    case (t)
      3'd0:    f = b ^ (c | ~d);
      3'd1:    f = (b & d) | (c & ~d);
      3'd2:    f = (b | ~c) ^ d;
      3'd3:    f = (b & c) | (~b & d);
      default: f = b ^ c ^ d;
    endcase
    return {e, rol(a + f + m + k, s), b, rol(c, 8'd10), d};
  endfunction

  function automatic logic [159:0] run_line(input logic [511:0] blk, input logic [159:0] h,
                                            input bit left);
    logic [159:0] w, d;
    int rd;
    w = h;
    for (int j = 0; j < 80; j++) begin
      rd = j / 16;
      if (left) d = dp_step(w, blk[32*RL[j] +: 32], KL[rd], 8'(SL[j]), 3'(4 - rd));
      else      d = dp_step(w, blk[32*RR[j] +: 32], KR[rd], 8'(SR[j]), 3'(rd));
      w = {d[159:128], d[127:96] + w[31:0], d[95:0]};
    end
    return w;
  endfunction

  always_comb begin
    sb_result = dp_step(sb_data, sb_m, sb_k, sb_s, sb_t);
    if (stub_mode) sb_result = {sb_data[159:128], 32'hFFFFFFFF, sb_data[95:0]};
  end

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  logic [159:0] exp_q[$];
  logic [159:0] last_res = '0;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_cyc <= cyc + 1;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic monitor();
    logic ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && !ov_prev) chk("latency", 160'(cyc - acc_cyc), 160'd80);
      ov_prev = rst_n && out_valid;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_result");
        else chk("result", result, exp_q.pop_front());
        last_res = result;
      end
    end
  endtask

  // Returns at the falling edge where the DUT presents step 0.
  task automatic send(input logic [511:0] blk, input logic [159:0] h);
    int n = 0;
    @(negedge clk);
    block_in = blk; h_in = h; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) fail("accept_timeout");
    @(negedge clk);
    in_valid = 1'b0;
    block_in = '1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      fail(name);
      exp_q.delete();
    end
  endtask

  logic [511:0] blk_a, blk_b, blk_e;
  logic [159:0] lft, dig, held, he;
  logic         ok;
  int           n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; block_in = '0; h_in = '0; stub_mode = 1'b0;
`ifdef RIPEMD_RIGHT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      blk_a[32*i +: 32] = 32'hC0DE0000 | 32'(i);
      blk_b[32*i +: 32] = 32'(i) * 32'h11111111 + 32'h01234567;
    end
    blk_e = '0;
    blk_e[7:0] = 8'h80;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 160'(in_ready), 160'd0);
    chk("rst_out_valid", 160'(out_valid), 160'd0);
    chk("rst_result", result, '0);
    chk("rst_work", sb_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 160'(in_ready), 160'd1);
    chk("idle_sb", 160'({sb_m, sb_k, sb_s, sb_t}), '0);

    // Schedule taps on a block whose words encode their own index.
    exp_q.push_back(run_line(blk_a, H0, 1'b0));
    send(blk_a, H0);
    chk("s0_data", sb_data, H0);
    chk("s0_m", 160'(sb_m), 160'h C0DE0005);
    chk("s0_sk_t", 160'({sb_s, sb_k, sb_t}), 160'({8'd8, 32'h50A28BE6, 3'd0}));
    repeat (15) @(negedge clk);
    chk("s15_m_s", 160'({sb_m, sb_s}), 160'({32'hC0DE000C, 8'd6}));
    @(negedge clk);
    chk("s16_all", 160'({sb_m, sb_s, sb_k, sb_t}), 160'({32'hC0DE0006, 8'd9, 32'h5C4DD124, 3'd1}));
    repeat (63) @(negedge clk);
    chk("s79_all", 160'({sb_m, sb_s, sb_k, sb_t}), 160'({32'hC0DE000B, 8'd11, 32'h0, 3'd4}));
    wait_drain("sched_drain");
    @(negedge clk);
    chk("idle_sb_after", 160'({sb_m, sb_k, sb_s, sb_t}), '0);

    // Empty message: right line from DUT, left line in software, folded into the known digest.
    exp_q.push_back(run_line(blk_e, H0, 1'b0));
    send(blk_e, H0);
    wait_drain("empty_drain");
    lft = run_line(blk_e, H0, 1'b1);
    dig[159:128] = H0[127:96] + lft[95:64]   + last_res[63:32];
    dig[127:96]  = H0[95:64]  + lft[63:32]   + last_res[31:0];
    dig[95:64]   = H0[63:32]  + lft[31:0]    + last_res[159:128];
    dig[63:32]   = H0[31:0]   + lft[159:128] + last_res[127:96];
    dig[31:0]    = H0[159:128] + lft[127:96] + last_res[95:64];
    chk("empty_digest", dig, 160'hA585119C_54FCE9C5_97082861_48F5E87E_318D25B2);

    // Backpressure.
    out_ready = 1'b0;
    exp_q.push_back(run_line(blk_b, H0, 1'b0));
    send(blk_b, H0);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) fail("bp_valid_timeout");
    held = result;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    chk("bp_hold", 160'(ok), 160'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 160'({out_valid, in_ready}), 160'(2'b01));
    wait_drain("bp_drain");
    exp_q.push_back(run_line(blk_a, blk_b[159:0], 1'b0));
    send(blk_a, blk_b[159:0]);
    wait_drain("second_drain");

    // +E wrap: stub B slot 0xFFFFFFFF plus E=2.
    stub_mode = 1'b1;
    he = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h00000002};
    exp_q.push_back({he[159:128], 32'h00000001, he[95:0]});
    send(blk_a, he);
    @(negedge clk);
    chk("plusE_step1", sb_data, {he[159:128], 32'h00000001, he[95:0]});
    wait_drain("plusE_drain");
    stub_mode = 1'b0;

    // Reset in the middle of RUN.
    send(blk_a, H0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 160'({out_valid, in_ready}), '0);
    chk("midrst_work", sb_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 160'(in_ready), 160'd1);
    ok = 1'b0;
    repeat (100) begin @(negedge clk); if (out_valid) ok = 1'b1; end
    chk("midrst_no_result", 160'(ok), 160'd0);

`ifdef RIPEMD_RIGHT_SEQ_ABORT_EN
    send(blk_a, H0);
    repeat (79) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 160'({out_valid, in_ready}), 160'(2'b01));
    ok = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid) ok = 1'b1; end
    chk("abort_no_result", 160'(ok), 160'd0);
`endif

    if (exp_q.size() != 0) fail("leftover_expected");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
